// File: rtl/datagram_uart_tx.sv
// datagram_uart_tx: serialises one MSG_BITS-wide datagram as an 8N1 byte stream.
// The frame is a HEADER sync byte followed by the payload bytes, least significant
// byte first. Each byte is sent LSB first.
// Ports:
//   clk        system clock (rising edge)
//   rst        asynchronous active-low reset
//   datagram   payload, latched when a send is accepted
//   send       transmit request; accepted when ready is high
//   ready      a new send will be accepted (registered)
//   TxD        serial line, idle high (registered)
//   busy       frame in flight, always the complement of ready (registered)
//   frame_done one-cycle pulse in the cycle after the last stop bit (registered)
module datagram_uart_tx #(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned BAUD     = 9600,
    parameter int unsigned MSG_BITS = 32,
    parameter logic [7:0]  HEADER   = 8'hA5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [MSG_BITS-1:0] datagram,
    input  logic                send,
    output logic                ready,
    output logic                TxD,
    output logic                busy,
    output logic                frame_done
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned NBYTES       = (MSG_BITS + 7) / 8;
    localparam int unsigned PAY_W        = NBYTES * 8;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int unsigned BYTE_W       = $clog2(NBYTES + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_e;

    state_e             state_q,   state_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic [2:0]         bit_q,     bit_d;
    logic [BYTE_W-1:0]  byte_q,    byte_d;
    logic [7:0]         shreg_q,   shreg_d;
    logic [PAY_W-1:0]   payload_q, payload_d;
    logic               tx_q,      tx_d;
    logic               busy_q,    busy_d;
    logic               ready_q,   ready_d;
    logic               done_q,    done_d;
    logic               bit_end;

    assign bit_end = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        shreg_d   = shreg_q;
        payload_d = payload_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        ready_d   = ready_q;
        done_d    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (send && ready_q) begin
                    payload_d = PAY_W'(datagram);
                    shreg_d   = HEADER;
                    byte_d    = '0;
                    state_d   = S_START;
                    tx_d      = 1'b0;
                    busy_d    = 1'b1;
                    ready_d   = 1'b0;
                end
            end
            S_START: begin
                cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
                if (bit_end) begin
                    state_d = S_DATA;
                    bit_d   = 3'd0;
                    tx_d    = shreg_q[0];
                end
            end
            S_DATA: begin
                cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shreg_d = shreg_q >> 1;
                        // Present the next bit now so TxD changes on the boundary.
                        tx_d    = shreg_q[1];
                    end
                end
            end
            S_STOP: begin
                cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
                if (bit_end) begin
                    if (byte_q < BYTE_W'(NBYTES)) begin
                        // Payload is consumed from the bottom, one byte per stop bit.
                        byte_d    = byte_q + BYTE_W'(1);
                        shreg_d   = payload_q[7:0];
                        payload_d = payload_q >> 8;
                        state_d   = S_START;
                        tx_d      = 1'b0;
                    end else begin
                        byte_d  = '0;
                        state_d = S_IDLE;
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                        ready_d = 1'b1;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            byte_q    <= '0;
            shreg_q   <= '0;
            payload_q <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            shreg_q   <= shreg_d;
            payload_q <= payload_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
        end
    end

    assign TxD        = tx_q;
    assign busy       = busy_q;
    assign ready      = ready_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_datagram_uart_tx.sv
// Testbench for datagram_uart_tx: two instances (16-bit and 12-bit payloads) at
// 10 clocks per bit. A line decoder per instance pops expected bytes from a queue.
module tb_datagram_uart_tx;

    logic        clk;
    logic        rst;
    logic [15:0] dg_a;
    logic        send_a, ready_a, txd_a, busy_a, done_a;
    logic [11:0] dg_b;
    logic        send_b, ready_b, txd_b, busy_b, done_b;

    int tests = 0;
    int fails = 0;

    logic [7:0] q_a[$];
    logic [7:0] q_b[$];
    int         dcnt_a = 0;

    datagram_uart_tx #(.CLK_FREQ(1000), .BAUD(100), .MSG_BITS(16), .HEADER(8'hA5)) u_a (
        .clk(clk), .rst(rst), .datagram(dg_a), .send(send_a),
        .ready(ready_a), .TxD(txd_a), .busy(busy_a), .frame_done(done_a)
    );

    datagram_uart_tx #(.CLK_FREQ(1000), .BAUD(100), .MSG_BITS(12), .HEADER(8'hA5)) u_b (
        .clk(clk), .rst(rst), .datagram(dg_b), .send(send_b),
        .ready(ready_b), .TxD(txd_b), .busy(busy_b), .frame_done(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endfunction

    // Line decoder: start detected at count 0, bit k sampled at count k*10+5.
    logic       mb[2];
    int         mc[2];
    logic [7:0] sh[2];
    initial begin
        mb[0] = 1'b0; mb[1] = 1'b0;
        mc[0] = 0;    mc[1] = 0;
        sh[0] = '0;   sh[1] = '0;
        forever begin
            @(negedge clk);
            if (rst && done_a) dcnt_a++;
            for (int i = 0; i < 2; i++) begin
                logic txv;
                int   k;
                txv = (i == 0) ? txd_a : txd_b;
                if (!rst) begin
                    mb[i] = 1'b0;
                end else if (!mb[i]) begin
                    if (!txv) begin
                        mb[i] = 1'b1;
                        mc[i] = 0;
                    end
                end else begin
                    mc[i]++;
                    if (mc[i] % 10 == 5) begin
                        k = mc[i] / 10;
                        if (k == 0) begin
                            chk("start_bit", 32'(txv), 32'd0);
                        end else if (k <= 8) begin
                            sh[i][k-1] = txv;
                        end else begin
                            chk("stop_bit", 32'(txv), 32'd1);
                            if (i == 0) begin
                                chk("queue_a_nonempty", 32'(q_a.size() != 0), 32'd1);
                                if (q_a.size() != 0) chk("byte_a", 32'(sh[i]), 32'(q_a.pop_front()));
                            end else begin
                                chk("queue_b_nonempty", 32'(q_b.size() != 0), 32'd1);
                                if (q_b.size() != 0) chk("byte_b", 32'(sh[i]), 32'(q_b.pop_front()));
                            end
                        end
                    end else if (mc[i] == 5) begin
                        chk("start_bit", 32'(txv), 32'd0);
                    end
                    if (mc[i] == 99) mb[i] = 1'b0;
                end
            end
        end
    end

    // Count cycles until frame_done of the selected instance, bounded.
    task automatic wait_done(input int sel, input int maxc, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!((sel == 0) ? done_a : done_b) && n < maxc);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        int   bcnt;
        int   d0;
        logic ok;

        rst = 1'b0; send_a = 1'b0; send_b = 1'b0; dg_a = '0; dg_b = '0;

        // Reset and idle.
        repeat (5) @(posedge clk);
        #1;
        chk("reset_state", 32'({txd_a, ready_a, busy_a, done_a}), 32'b1100);
        rst = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk);
            #1;
            chk("idle_state", 32'({txd_a, ready_a, busy_a, done_a, txd_b, ready_b, busy_b, done_b}), 32'b1100_1100);
        end

        // Single frame 16'h1234: start at +1, 300 busy cycles, done at +301.
        dg_a = 16'h1234; send_a = 1'b1;
        q_a.push_back(8'hA5); q_a.push_back(8'h34); q_a.push_back(8'h12);
        @(posedge clk);
        #1;
        send_a = 1'b0;
        chk("first_start_bit", 32'({txd_a, busy_a, ready_a}), 32'b010);
        n = 1; bcnt = 1;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (busy_a) bcnt++;
        end while (!done_a && n < 400);
        chk("done_cycle", 32'(n), 32'd301);
        chk("busy_span", 32'(bcnt), 32'd300);
        chk("done_ready", 32'({ready_a, busy_a, txd_a}), 32'b101);
        @(posedge clk);
        #1;
        chk("done_one_cycle", 32'(done_a), 32'd0);

        // Request mid-frame is ignored and datagram changes have no effect.
        dg_a = 16'h1234; send_a = 1'b1;
        q_a.push_back(8'hA5); q_a.push_back(8'h34); q_a.push_back(8'h12);
        @(posedge clk);
        #1;
        send_a = 1'b0;
        repeat (150) @(posedge clk);
        #1;
        dg_a = 16'hFFFF; send_a = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("ignored_ready_low", 32'({ready_a, busy_a}), 32'b01);
        send_a = 1'b0;
        wait_done(0, 400, n);
        chk("ignored_done", 32'(done_a), 32'd1);
        ok = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk);
            #1;
            if (!txd_a || busy_a) ok = 1'b0;
        end
        chk("no_second_frame", 32'(ok), 32'd1);

        // Back-to-back with send held.
        d0 = dcnt_a;
        dg_a = 16'h00FF; send_a = 1'b1;
        q_a.push_back(8'hA5); q_a.push_back(8'hFF); q_a.push_back(8'h00);
        @(posedge clk);
        #1;
        dg_a = 16'hAA55;
        q_a.push_back(8'hA5); q_a.push_back(8'h55); q_a.push_back(8'hAA);
        wait_done(0, 400, n);
        chk("b2b_first_done", 32'(n), 32'd300);
        chk("b2b_idle_gap", 32'({txd_a, ready_a}), 32'b11);
        @(posedge clk);
        #1;
        send_a = 1'b0;
        chk("b2b_second_start", 32'({txd_a, busy_a, done_a}), 32'b010);
        wait_done(0, 400, n);
        chk("b2b_second_done", 32'(n), 32'd300);
        @(posedge clk);
        #1;
        chk("b2b_done_pulses", 32'(dcnt_a - d0), 32'd2);

        // Zero padding of a 12-bit datagram.
        dg_b = 12'hABC; send_b = 1'b1;
        q_b.push_back(8'hA5); q_b.push_back(8'hBC); q_b.push_back(8'h0A);
        @(posedge clk);
        #1;
        send_b = 1'b0;
        wait_done(1, 400, n);
        chk("pad_done", 32'(n), 32'd300);
        repeat (3) @(posedge clk);

        // Asynchronous reset during byte 1 data, then a clean frame.
        #1;
        dg_a = 16'h5A3C; send_a = 1'b1;
        q_a.push_back(8'hA5); q_a.push_back(8'h3C); q_a.push_back(8'h5A);
        @(posedge clk);
        #1;
        send_a = 1'b0;
        repeat (140) @(posedge clk);
        #4;
        rst = 1'b0;
        #1;
        chk("abort_async", 32'({txd_a, ready_a, busy_a, done_a}), 32'b1100);
        chk("abort_header_seen", 32'(q_a.size()), 32'd2);
        q_a.delete();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_release", 32'({txd_a, ready_a, busy_a}), 32'b110);
        dg_a = 16'h0102; send_a = 1'b1;
        q_a.push_back(8'hA5); q_a.push_back(8'h02); q_a.push_back(8'h01);
        @(posedge clk);
        #1;
        send_a = 1'b0;
        wait_done(0, 400, n);
        chk("post_reset_done", 32'(n), 32'd300);
        repeat (5) @(posedge clk);
        #1;
        chk("queue_a_drained", 32'(q_a.size()), 32'd0);
        chk("queue_b_drained", 32'(q_b.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/datagram_uart_tx.md
Name: datagram_uart_tx

Overview:
- UART transmitter: serialises one MSG_BITS-wide datagram onto TxD as a framed 8N1 byte stream.
- Peer of the mother-board receive path: a sensor/controller board runs this block, and the mother board's RxD input decodes the stream back into `datagram`.
- Sits between the local game-state logic (which supplies datagram/send) and the board's TxD pin.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD, 9600, line rate in bits/s; CLKS_PER_BIT = CLK_FREQ/BAUD (integer division, must be >= 2).
- MSG_BITS, 32, datagram width; NBYTES = ceil(MSG_BITS/8).
- HEADER, 8'hA5, sync byte sent before the payload.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- datagram  input  MSG_BITS  payload; sampled only on acceptance.
- send  input  1  request to transmit; valid-style, may be held.
- ready  output  1  high when a new send will be accepted.
- TxD  output  1  serial line; idle high.
- busy  output  1  high from the cycle after acceptance until the frame ends.
- frame_done  output  1  one-cycle pulse at the end of a frame.

Behaviour:
- Reset (rst=0, asynchronous): TxD=1, ready=1, busy=0, frame_done=0, FSM=IDLE, all counters 0, latched payload 0. Reset mid-frame aborts immediately; TxD goes high with no partial stop bit. No frame starts until rst has been high for at least one clock.
- Acceptance: on a clock edge where send=1 and ready=1:
  - datagram is latched, zero-padded to NBYTES*8 bits;
  - next cycle: ready=0, busy=1.
  - send while ready=0 is ignored, not queued.
- Frame order: HEADER, then payload bytes least-significant byte first (byte0 = datagram[7:0]). Each byte is sent LSB first.
- Byte format: 1 start bit (0), 8 data bits, 1 stop bit (1).
- No idle gap between bytes: the next start bit immediately follows the previous stop bit.
- Timing:
  - TxD is registered; the start bit of HEADER appears in the cycle after acceptance.
  - Every bit lasts exactly CLKS_PER_BIT cycles.
  - Frame length is (NBYTES+1)*10*CLKS_PER_BIT cycles.
- FSM states:
  - IDLE: TxD=1, ready=1. Goes to START on acceptance.
  - START: TxD=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: bit index 0..7, shift register advances once per bit period. After bit 7, goes to STOP.
  - STOP: TxD=1 for CLKS_PER_BIT cycles. If byte index < NBYTES, increments byte index and goes to START; otherwise goes to IDLE.
- Byte index is 0 for HEADER and 1..NBYTES for payload. Its width is clog2(NBYTES+1); it never wraps within a frame.
- Baud counter counts 0..CLKS_PER_BIT-1 and reloads to 0 at each bit boundary. It is held at 0 in IDLE.
- End of frame:
  - In the cycle after the last stop bit completes: frame_done=1 for exactly one cycle, ready=1, busy=0.
  - If send=1 in that same cycle, the next frame is accepted there. Its start bit follows one cycle later, giving one idle-high cycle between frames.
- Changes to datagram after acceptance have no effect on the frame in flight.
- Outputs ready and busy are always complementary.

Test Plan:
- Reset idle: hold rst=0 for 5 cycles, release, send=0 for 50 cycles -> TxD=1, ready=1, busy=0, frame_done=0 throughout.
- Single frame (CLK_FREQ=1000, BAUD=100 so 10 clk/bit; MSG_BITS=16; datagram=16'h1234; pulse send):
  - decoded bytes are A5, 34, 12;
  - start bit at cycle +1; frame spans exactly 300 cycles;
  - frame_done pulses once at cycle +301, and ready=1 there.
- Ignored request: assert send with datagram=16'hFFFF mid-frame of 16'h1234 -> transmitted bytes remain A5, 34, 12; no second frame follows.
- Back-to-back: hold send=1 with 16'h00FF then 16'hAA55 -> two frames A5,FF,00 and A5,55,AA; exactly one idle-high cycle between them; two frame_done pulses.
- Padding: MSG_BITS=12, datagram=12'hABC -> bytes A5, BC, 0A.
- Reset mid-operation: drive rst=0 during the DATA state of byte 1 -> TxD=1 asynchronously; after release, ready=1. A new send of 16'h0102 produces a clean A5, 02, 01 frame.
